// File: rtl/dm_access_ctrl.sv
// Load/store unit between the integer datapath and a big-endian byte memory.
// Sub-word stores are a read-modify-write of the aligned word; loads are lane-extracted and extended.
module dm_access_ctrl #(
    parameter int unsigned MEM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        ack,
    output logic        err,
    output logic [31:0] rdata,
    output logic        dm_cs,
    output logic        dm_rd,
    output logic        dm_wr,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_din,
    input  logic [31:0] dm_dout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        sext_q, sext_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rbuf_q, rbuf_d;
    logic        busy_q, busy_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic        bad_req;

    // Replace the addressed big-endian lane of the word read back in RD.
    function automatic logic [31:0] merge_lane(input logic [31:0] rbuf, input logic [31:0] wd,
                                               input logic [1:0] sz, input logic [1:0] off);
        logic [31:0] m;
        m = rbuf;
        case (sz)
            2'b00: begin
                case (off)
                    2'd0:    m[31:24] = wd[7:0];
                    2'd1:    m[23:16] = wd[7:0];
                    2'd2:    m[15:8]  = wd[7:0];
                    default: m[7:0]   = wd[7:0];
                endcase
            end
            2'b01: begin
                if (off[1]) m[15:0]  = wd[15:0];
                else        m[31:16] = wd[15:0];
            end
            default: m = wd;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] load_lane(input logic [31:0] word, input logic [1:0] sz,
                                              input logic [1:0] off, input logic sx);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        h = off[1] ? word[15:0] : word[31:16];
        case (sz)
            2'b00:   r = {{24{sx & b[7]}}, b};
            2'b01:   r = {{16{sx & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    always_comb begin
        bad_req = (size == 2'b11) || (addr >= MEM_BYTES) ||
                  (size == 2'b01 && addr[0]) ||
                  (size == 2'b10 && addr[1:0] != 2'b00);
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        sext_d  = sext_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rbuf_d  = rbuf_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    we_d    = we;
                    size_d  = size;
                    sext_d  = sign_ext;
                    addr_d  = addr;
                    wdata_d = wdata;
                    if (bad_req)                        state_d = S_ERR;
                    else if (!we || size != 2'b10)      state_d = S_RD;
                    else                                state_d = S_WR;
                end
            end
            S_RD: begin
                rbuf_d = dm_dout;
                if (we_q) begin
                    state_d = S_WR;
                end else begin
                    // Load result lands in rdata on the same edge that enters DONE.
                    rdata_d = load_lane(dm_dout, size_q, addr_q[1:0], sext_q);
                    state_d = S_DONE;
                end
            end
            S_WR:    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
        ack_d  = (state_d == S_DONE) || (state_d == S_ERR);
        err_d  = (state_d == S_ERR);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            sext_q  <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rbuf_q  <= 32'h0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            sext_q  <= sext_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rbuf_q  <= rbuf_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Memory strobes decode straight from state so they drop the instant reset hits.
    always_comb begin
        dm_cs   = (state_q == S_RD) || (state_q == S_WR);
        dm_rd   = (state_q == S_RD);
        dm_wr   = (state_q == S_WR);
        dm_addr = dm_cs ? {addr_q[31:2], 2'b00} : 32'h0;
        dm_din  = dm_wr ? merge_lane(rbuf_q, wdata_q, size_q, addr_q[1:0]) : 32'h0;
    end

    assign busy  = busy_q;
    assign ack   = ack_q;
    assign err   = err_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Bench for dm_access_ctrl: byte-array memory model, transaction-level reference, per-cycle compare.
module tb_dm_access_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req = 1'b0, we = 1'b0, sign_ext = 1'b0;
    logic [1:0]  size = 2'b00;
    logic [31:0] addr = 32'h0, wdata = 32'h0;
    logic        busy, ack, err, dm_cs, dm_rd, dm_wr;
    logic [31:0] rdata, dm_addr, dm_din, dm_dout;

    dm_access_ctrl #(.MEM_BYTES(4096)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
        .addr(addr), .wdata(wdata), .busy(busy), .ack(ack), .err(err), .rdata(rdata),
        .dm_cs(dm_cs), .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_din(dm_din),
        .dm_dout(dm_dout)
    );

    always #5 clk = ~clk;

    logic [7:0] mem[4096];
    logic [7:0] ref_mem[4096];

    assign dm_dout = (dm_cs && dm_rd) ?
        {mem[{dm_addr[11:2], 2'd0}], mem[{dm_addr[11:2], 2'd1}],
         mem[{dm_addr[11:2], 2'd2}], mem[{dm_addr[11:2], 2'd3}]} : 32'h0;

    always @(posedge clk)
        if (dm_cs && dm_wr)
            for (int i = 0; i < 4; i++) mem[{dm_addr[11:2], 2'(i)}] <= dm_din[31-8*i -: 8];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_fail = 0, n_done = 0;
    bit pending = 0;
    int req_cyc, exp_lat, last_lat;
    bit t_err, t_we;
    logic [1:0]  t_size;
    logic [31:0] t_addr, t_din, t_new_rdata, cur_rdata = 32'h0, last_din = 32'h0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: what a request must produce, from byte-level memory contents.
    task automatic setup();
        logic [7:0]  b[4];
        logic [31:0] v;
        int n, o;
        t_we = we; t_size = size; t_addr = addr;
        t_err = (size == 2'd3) || (addr >= 32'd4096) || (size == 2'd1 && addr[0]) ||
                (size == 2'd2 && addr[1:0] != 2'd0);
        exp_lat = t_err ? 1 : (we && size != 2'd2) ? 3 : 2;
        n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        t_new_rdata = cur_rdata;
        t_din = 32'h0;
        if (!t_err) begin
            o = int'(addr[1:0]);
            for (int i = 0; i < 4; i++) b[i] = ref_mem[{addr[11:2], 2'(i)}];
            if (!we) begin
                v = 32'h0;
                for (int i = 0; i < n; i++) v = {v[23:0], b[o+i]};
                if (sign_ext && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
                t_new_rdata = v;
            end else begin
                for (int i = 0; i < n; i++) b[o+i] = 8'(wdata >> (8*(n-1-i)));
                t_din = {b[0], b[1], b[2], b[3]};
            end
        end
        req_cyc = cyc;
        pending = 1;
    endtask

    always @(negedge clk) begin
        int k;
        bit exp_rd, exp_wr;
        if (dm_wr) last_din = dm_din;
        if (!reset) begin
            chk("rst_ctl", {26'h0, busy, ack, err, dm_cs, dm_rd, dm_wr}, 32'h0);
            chk("rst_rdata", rdata, 32'h0);
            chk("rst_dm", dm_addr | dm_din, 32'h0);
        end else begin
            chk("rd_wr_excl", {31'h0, dm_rd & dm_wr}, 32'h0);
            chk("din_idle", dm_wr ? 32'h0 : dm_din, 32'h0);
            chk("addr_idle", dm_cs ? 32'h0 : dm_addr, 32'h0);
            chk("cs_decode", {31'h0, dm_cs}, {31'h0, dm_rd | dm_wr});
            if (pending) begin
                k = cyc - req_cyc;
                exp_rd = !t_err && k == 1 && (!t_we || t_size != 2'd2);
                exp_wr = !t_err && t_we && ((t_size == 2'd2 && k == 1) || (t_size != 2'd2 && k == 2));
                chk("busy", {31'h0, busy}, {31'h0, (k >= 1 && k <= exp_lat)});
                chk("ack", {31'h0, ack}, {31'h0, (k == exp_lat)});
                chk("err", {31'h0, err}, {31'h0, (k == exp_lat && t_err)});
                chk("dm_rd", {31'h0, dm_rd}, {31'h0, exp_rd});
                chk("dm_wr", {31'h0, dm_wr}, {31'h0, exp_wr});
                if (dm_cs) chk("dm_addr", dm_addr, {t_addr[31:2], 2'b00});
                if (exp_wr) chk("dm_din", dm_din, t_din);
                chk("rdata", rdata, (k >= exp_lat) ? t_new_rdata : cur_rdata);
                if (k >= exp_lat) begin
                    if (t_we && !t_err)
                        for (int i = 0; i < 4; i++) ref_mem[{t_addr[11:2], 2'(i)}] = t_din[31-8*i -: 8];
                    if (!t_err)
                        chk("mem_word",
                            {mem[{t_addr[11:2], 2'd0}], mem[{t_addr[11:2], 2'd1}],
                             mem[{t_addr[11:2], 2'd2}], mem[{t_addr[11:2], 2'd3}]},
                            {ref_mem[{t_addr[11:2], 2'd0}], ref_mem[{t_addr[11:2], 2'd1}],
                             ref_mem[{t_addr[11:2], 2'd2}], ref_mem[{t_addr[11:2], 2'd3}]});
                    cur_rdata = t_new_rdata;
                    last_lat = k;
                    pending = 0;
                    n_done++;
                end
            end else begin
                chk("idle_ctl", {29'h0, busy, ack, err}, 32'h0);
                chk("idle_rdata", rdata, cur_rdata);
            end
        end
    end

    task automatic wait_done(input int target);
        for (int i = 0; i < 20 && n_done < target; i++) begin
            @(posedge clk); #1;
        end
        if (n_done < target) begin
            n_chk++; n_fail++;
            $display("FAIL ack_timeout: got no ack expected ack within 20 cycles (cyc %0d)", cyc);
            pending = 0;
        end
    endtask

    task automatic issue(input bit w, input logic [1:0] s, input bit sx, input logic [31:0] a,
                         input logic [31:0] d, input bit hold = 0, input bit poke = 0);
        int target;
        we = w; size = s; sign_ext = sx; addr = a; wdata = d; req = 1'b1;
        setup();
        target = n_done + 1;
        @(posedge clk); #1;
        if (!hold) req = 1'b0;
        if (poke) begin
            req = 1'b1;
            @(posedge clk); #1;
            req = 1'b0;
        end
        wait_done(target);
        if (hold) begin
            setup();
            @(posedge clk); #1;
            req = 1'b0;
            wait_done(target + 1);
        end
    endtask

    initial begin
        int bad;
        bit w, hold, poke;
        logic [1:0]  s;
        logic [31:0] a;
        for (int i = 0; i < 4096; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;

        issue(1, 2'd2, 0, 32'h10, 32'hDEADBEEF);
        chk("t1_st_lat", last_lat, 2);
        issue(0, 2'd2, 0, 32'h10, 32'h0);
        chk("t1_ld_lat", last_lat, 2);
        chk("t1_rdata", rdata, 32'hDEADBEEF);
        chk("t1_mem", {mem[16], mem[17], mem[18], mem[19]}, 32'hDEADBEEF);

        issue(1, 2'd2, 0, 32'h10, 32'h11223344);
        issue(1, 2'd0, 0, 32'h12, 32'h00000055);
        chk("t2_din", last_din, 32'h11225544);
        chk("t2_lat", last_lat, 3);

        issue(1, 2'd2, 0, 32'h20, 32'h80FF7F01);
        issue(0, 2'd0, 1, 32'h20, 32'h0);  chk("t3_lb", rdata, 32'hFFFFFF80);
        issue(0, 2'd0, 0, 32'h21, 32'h0);  chk("t3_lbu", rdata, 32'h000000FF);
        issue(0, 2'd1, 1, 32'h22, 32'h0);  chk("t3_lh", rdata, 32'h00007F01);
        issue(0, 2'd1, 0, 32'h20, 32'h0);  chk("t3_lhu", rdata, 32'h000080FF);

        issue(0, 2'd1, 0, 32'h13, 32'h0);    chk("t4_half_lat", last_lat, 1);
        issue(1, 2'd2, 0, 32'h02, 32'h0);    chk("t4_word_lat", last_lat, 1);
        issue(1, 2'd3, 0, 32'h20, 32'h0);    chk("t4_size_lat", last_lat, 1);
        issue(1, 2'd2, 0, 32'h1000, 32'h0);  chk("t4_range_lat", last_lat, 1);
        chk("t4_rdata", rdata, 32'h000080FF);

        issue(0, 2'd2, 0, 32'h20, 32'h0, 0, 1);  chk("t5_poke", rdata, 32'h80FF7F01);
        issue(0, 2'd0, 1, 32'h21, 32'h0, 1, 0);  chk("t5_hold", rdata, 32'hFFFFFFFF);
        chk("t5_hold_lat", last_lat, 2);

        // Abort a byte store while it sits in RD.
        we = 1'b1; size = 2'd0; sign_ext = 1'b0; addr = 32'h12; wdata = 32'hAA; req = 1'b1;
        setup();
        @(posedge clk); #1;
        req = 1'b0;
        reset = 1'b0;
        pending = 0;
        #1 chk("t6_abort", {26'h0, busy, ack, err, dm_cs, dm_rd, dm_wr}, 32'h0);
        chk("t6_rdata", rdata, 32'h0);
        cur_rdata = 32'h0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        issue(0, 2'd2, 0, 32'h10, 32'h0);  chk("t6_old", rdata, 32'h11225544);

        for (int t = 0; t < 300; t++) begin
            w = 1'($urandom);
            s = ($urandom % 16 == 0) ? 2'd3 : 2'($urandom % 3);
            case ($urandom % 20)
                0:       a = $urandom;
                1:       a = 32'hFFC + ($urandom % 8);
                default: a = $urandom % 64;
            endcase
            if ($urandom % 8 != 0) begin
                if (s == 2'd1) a[0] = 1'b0;
                if (s == 2'd2) a[1:0] = 2'b00;
            end
            poke = ($urandom % 8 == 0);
            hold = !poke && ($urandom % 10 == 0);
            issue(w, s, 1'($urandom), a, $urandom, hold, poke);
        end

        bad = 0;
        for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) bad++;
        chk("mem_sweep", bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
